// File: rtl/fetch_seq_pkg.sv
// Shared types and helpers for the PC next-address sequencer.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } seq_state_t;

  localparam int unsigned PC_W = 64;

  // True when any of the low $clog2(bytes) address bits is set.
  function automatic logic misaligned(input logic [PC_W-1:0] addr,
                                      input int unsigned     bytes);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < PC_W; i++) begin
      if (((64'(1) << i) < 64'(bytes)) && addr[i]) begin
        r = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Next-address controller for the program counter: sequential increment,
// stall hold, immediate or deferred branch redirect, halt and fault handling.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned INSN_BYTES   = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic [PC_W-1:0] next_pc,
  output logic            fetch_valid,
  output logic            flush,
  output logic            fault,
  output logic            halted
);

  seq_state_t      r_state;
  logic            r_pend_v;
  logic [PC_W-1:0] r_pend_pc;
  logic [2:0]      r_flush_cnt;
  logic            r_fault;

  seq_state_t      w_state_nxt;
  logic            w_pend_v_nxt;
  logic [PC_W-1:0] w_pend_pc_nxt;
  logic [2:0]      w_cnt_nxt;
  logic            w_fault_nxt;
  logic [PC_W-1:0] w_next_pc;
  logic            w_apply;
  logic            w_bad;
  logic            w_br_bad;
  logic            w_pend_bad;

  // Next-PC selection, pending-redirect bookkeeping and FSM next state.
  always_comb begin
    w_next_pc     = pc + PC_W'(INSN_BYTES);
    w_state_nxt   = r_state;
    w_pend_v_nxt  = r_pend_v;
    w_pend_pc_nxt = r_pend_pc;
    w_cnt_nxt     = r_flush_cnt;
    w_fault_nxt   = r_fault;
    w_apply       = 1'b0;
    w_bad         = 1'b0;
    w_br_bad      = br_taken && misaligned(br_target, INSN_BYTES);
    w_pend_bad    = misaligned(r_pend_pc, INSN_BYTES);

    if ((r_state == HALT) || r_fault) begin
      w_next_pc = pc;
      // A faulted sequencer stays frozen until reset; resume is ignored.
      if (!r_fault) begin
        if (br_taken) begin
          if (w_br_bad) begin
            w_bad = 1'b1;
          end else begin
            w_pend_v_nxt  = 1'b1;
            w_pend_pc_nxt = br_target;
          end
        end
        if (resume && !halt_req) begin
          w_state_nxt = RUN;
        end
      end
    end else begin
      if (r_state == FLUSH) begin
        if (r_flush_cnt <= 3'd1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_flush_cnt - 3'd1;
        end
      end

      if (stall) begin
        w_next_pc = pc;
        if (br_taken) begin
          if (w_br_bad) begin
            w_bad = 1'b1;
          end else begin
            w_pend_v_nxt  = 1'b1;
            w_pend_pc_nxt = br_target;
          end
        end
      end else if (br_taken) begin
        if (w_br_bad) begin
          w_bad     = 1'b1;
          w_next_pc = pc;
        end else begin
          w_next_pc    = br_target;
          w_pend_v_nxt = 1'b0;
          w_apply      = 1'b1;
        end
      end else if (r_pend_v) begin
        w_pend_v_nxt = 1'b0;
        if (w_pend_bad) begin
          w_bad     = 1'b1;
          w_next_pc = pc;
        end else begin
          w_next_pc = r_pend_pc;
          w_apply   = 1'b1;
        end
      end

      if (w_apply) begin
        w_state_nxt = FLUSH;
        w_cnt_nxt   = 3'(FLUSH_CYCLES);
      end
      // Halt overrides the redirect's state change but not its next_pc.
      if (halt_req) begin
        w_state_nxt = HALT;
        w_cnt_nxt   = '0;
      end
    end

    if (w_bad) begin
      w_fault_nxt = 1'b1;
      w_state_nxt = HALT;
      w_cnt_nxt   = '0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_pend_v    <= 1'b0;
      r_pend_pc   <= '0;
      r_flush_cnt <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_v    <= w_pend_v_nxt;
      r_pend_pc   <= w_pend_pc_nxt;
      r_flush_cnt <= w_cnt_nxt;
      r_fault     <= w_fault_nxt;
    end
  end

  assign next_pc     = w_next_pc;
  assign flush       = (r_state == FLUSH);
  assign halted      = (r_state == HALT);
  assign fault       = r_fault;
  assign fetch_valid = (r_state != HALT) && !stall && !r_fault;

endmodule
